// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported synchronous 32-bit memory (1-cycle read latency).
// Define MEM_ARB_ROUND_ROBIN_EN for alternating contested grants; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  m0_valid,
    input  logic                  m0_write,
    input  logic [3:0]            m0_wmask,
    input  logic [31:0]           m0_wdata,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_valid,
    input  logic                  m1_write,
    input  logic [3:0]            m1_wmask,
    input  logic [31:0]           m1_wdata,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic                  m1_ready,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    // Handshake: a request transfers in the cycle where valid && ready; the master holds
    // all request fields stable until then. A read answers with rvalid exactly one cycle
    // after its transfer; a write has no response, ready is its completion.

    localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

    logic       last_q, last_d;
    logic [3:0] wait0_q, wait0_d;
    logic [3:0] wait1_q, wait1_d;
    logic [1:0] rtag_q, rtag_d;

    logic contested;
    logic starve0;
    logic starve1;
    logic gnt0;
    logic gnt1;

    always_comb begin
        contested = m0_valid & m1_valid;
        starve0   = (wait0_q >= MAX_WAIT_W);
        starve1   = (wait1_q >= MAX_WAIT_W);
        gnt0      = 1'b0;
        gnt1      = 1'b0;

        if (m0_valid && !m1_valid) begin
            gnt0 = 1'b1;
        end else if (m1_valid && !m0_valid) begin
            gnt1 = 1'b1;
        end else if (contested) begin
            // Starvation overrides the policy; port 0 wins if both are starved.
            if (starve0) begin
                gnt0 = 1'b1;
            end else if (starve1) begin
                gnt1 = 1'b1;
            end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                gnt0 = last_q;
                gnt1 = ~last_q;
`else
                gnt0 = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        m0_ready  = gnt0;
        m1_ready  = gnt1;
        mem_valid = gnt0 | gnt1;
        mem_write = gnt1 ? m1_write : m0_write;
        mem_wmask = gnt1 ? m1_wmask : m0_wmask;
        mem_wdata = gnt1 ? m1_wdata : m0_wdata;
        mem_addr  = gnt1 ? m1_addr  : m0_addr;

        m0_rdata  = mem_rdata;
        m1_rdata  = mem_rdata;
        m0_rvalid = rtag_q[0];
        m1_rvalid = rtag_q[1];
    end

    always_comb begin
        last_d = contested ? gnt1 : last_q;

        wait0_d = 4'd0;
        if (m0_valid && !gnt0) begin
            wait0_d = (wait0_q == 4'hF) ? 4'hF : wait0_q + 4'd1;
        end

        wait1_d = 4'd0;
        if (m1_valid && !gnt1) begin
            wait1_d = (wait1_q == 4'hF) ? 4'hF : wait1_q + 4'd1;
        end

        rtag_d = {gnt1 & ~m1_write, gnt0 & ~m0_write};
    end

    // Reset drops any outstanding read response; it is never replayed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q  <= 1'b1;
            wait0_q <= 4'd0;
            wait1_q <= 4'd0;
            rtag_q  <= 2'b00;
        end else begin
            last_q  <= last_d;
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
            rtag_q  <= rtag_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-ported memory (1-cycle read, byte mask).
// Expectations follow whichever arbitration policy MEM_ARB_ROUND_ROBIN_EN selects.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        m0_valid, m0_write, m0_ready, m0_rvalid;
    logic [3:0]  m0_wmask;
    logic [31:0] m0_wdata, m0_addr, m0_rdata;
    logic        m1_valid, m1_write, m1_ready, m1_rvalid;
    logic [3:0]  m1_wmask;
    logic [31:0] m1_wdata, m1_addr, m1_rdata;
    logic        mem_valid, mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;

    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] mem [0:255];

    int n_tests;
    int n_fail;
    logic [31:0] exp_q[$];

    mem_arbiter #(.ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- memory model with a bench-side preload port ----
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_valid) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    // ---- driver tasks ----
    task automatic drive0(input logic v, input logic w, input logic [3:0] m,
                          input logic [31:0] d, input logic [31:0] a);
        m0_valid = v; m0_write = w; m0_wmask = m; m0_wdata = d; m0_addr = a;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [3:0] m,
                          input logic [31:0] d, input logic [31:0] a);
        m1_valid = v; m1_write = w; m1_wmask = m; m1_wdata = d; m1_addr = a;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // ---- scoreboard compare ----
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_val(input int i);
        return 32'h5000_0000 | 32'(i);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1;
        logic e1, first;
        logic [31:0] got;

        n_tests = 0;
        n_fail  = 0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        rstn = 1'b0;
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(0, 0, 4'h0, 32'h0, 32'h0);

        // Reset state
        #3;
        check("rst_rv0", m0_rvalid, 0);
        check("rst_rv1", m1_rvalid, 0);
        check("rst_rdy0", m0_ready, 0);
        check("rst_rdy1", m1_ready, 0);
        check("rst_memv", mem_valid, 0);

        for (int i = 0; i < 16; i++) preload(8'(i), word_val(i));
        preload(8'h40, 32'hDEADBEEF);
        preload(8'h80, 32'hAAAAAAAA);
        rstn = 1'b1;
        next_cycle();

        // Single read on port 0
        drive0(1, 0, 4'h0, 32'h0, 32'h100);
        #1;
        check("rd0_ready", m0_ready, 1);
        check("rd0_other", m1_ready, 0);
        check("rd0_memv", mem_valid, 1);
        check("rd0_addr", mem_addr, 32'h100);
        next_cycle();
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        check("rd0_rvalid", m0_rvalid, 1);
        check("rd0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd0_rv1", m1_rvalid, 0);
        next_cycle();
        check("rd0_rv_once", m0_rvalid, 0);

        // Port 1 masked write then read-back
        drive1(1, 1, 4'b0011, 32'h12345678, 32'h200);
        #1;
        check("wr1_ready", m1_ready, 1);
        check("wr1_memw", mem_write, 1);
        check("wr1_mask", mem_wmask, 4'b0011);
        check("wr1_data", mem_wdata, 32'h12345678);
        next_cycle();
        check("wr1_norv", m1_rvalid, 0);
        drive1(1, 0, 4'h0, 32'h0, 32'h200);
        #1;
        check("rd1_ready", m1_ready, 1);
        next_cycle();
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        check("rd1_rvalid", m1_rvalid, 1);
        check("rd1_rdata", m1_rdata, 32'hAAAA5678);
        check("rd1_rv0", m0_rvalid, 0);

        // Both ports reading continuously
        a0 = 0;
        a1 = 8;
        for (int c = 0; c < 10; c++) begin
            drive0(1, 0, 4'h0, 32'h0, 32'(a0 * 4));
            drive1(1, 0, 4'h0, 32'h0, 32'(a1 * 4));
            #1;
            e1 = RR ? (c % 2 == 1) : (c % 5 == 4);
            check("str_gnt0", m0_ready, !e1);
            check("str_gnt1", m1_ready, e1);
            exp_q.push_back(word_val(e1 ? a1 : a0));
            next_cycle();
            check("str_rv0", m0_rvalid, !e1);
            check("str_rv1", m1_rvalid, e1);
            check("str_rdata", e1 ? m1_rdata : m0_rdata, exp_q.pop_front());
            if (e1) a1 = (a1 == 15) ? 8 : a1 + 1;
            else    a0 = (a0 + 1) % 8;
        end
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        next_cycle();
        check("str_end_rv0", m0_rvalid, 0);
        check("str_end_rv1", m1_rvalid, 0);

        // Reset while a read response is outstanding
        drive0(1, 0, 4'h0, 32'h0, 32'h100);
        next_cycle();
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        check("rst_pre_rv", m0_rvalid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_rv", m0_rvalid, 0);
        next_cycle();
        check("rst_hold_rv", m0_rvalid, 0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("rst_post_rv0", m0_rvalid, 0);
            check("rst_post_rv1", m1_rvalid, 0);
        end

        // Contested write (port 0) against read (port 1) after port 0 won a contest
        first = RR;
        drive0(1, 0, 4'h0, 32'h0, 32'h0);
        drive1(1, 0, 4'h0, 32'h0, 32'h20);
        #1;
        check("mix_pre_gnt0", m0_ready, 1);
        check("mix_pre_gnt1", m1_ready, 0);
        next_cycle();
        check("mix_pre_rdata", m0_rdata, word_val(0));
        drive0(1, 1, 4'hF, 32'hCAFEF00D, 32'h300);
        #1;
        check("mix_gnt0", m0_ready, !first);
        check("mix_gnt1", m1_ready, first);
        next_cycle();
        got = 32'h0;
        if (m1_rvalid) got = m1_rdata;
        if (first) drive1(0, 0, 4'h0, 32'h0, 32'h0);
        else       drive0(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("mix_gnt0_b", m0_ready, first);
        check("mix_gnt1_b", m1_ready, !first);
        next_cycle();
        if (m1_rvalid) got = m1_rdata;
        check("mix_wr_norv", m0_rvalid, 0);
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        check("mix_rd_data", got, word_val(8));
        drive1(1, 0, 4'h0, 32'h0, 32'h300);
        #1;
        check("mix_chk_ready", m1_ready, 1);
        next_cycle();
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        check("mix_chk_rv", m1_rvalid, 1);
        check("mix_chk_mem", m1_rdata, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one single-ported synchronous 32-bit memory (one-cycle read latency, byte write mask) between the pipeline's memory port (port 0) and a secondary master (port 1: program loader, DMA or debug). It grants at most one request per cycle, routes the granted request combinationally to the memory, and steers the returning read data to the owning port one cycle later. It sits between `Pipeline`/loader and `Memory32Sim` in simulation benches and in place of the direct connection in SoC tops.

## Interface
- `ADDR_WIDTH`, 32: width of master and memory address buses.
- `MAX_WAIT`, 4: consecutive denied cycles after which the starved port wins unconditionally (1..15).
- `clk` in 1: clock, all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `m0_valid`, `m1_valid` in 1: request present.
- `m0_write`, `m1_write` in 1: 1 = write, 0 = read.
- `m0_wmask`, `m1_wmask` in 4: byte enables for writes.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_addr`, `m1_addr` in ADDR_WIDTH: byte address, passed through unchanged.
- `m0_ready`, `m1_ready` out 1: request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid` out 1: read data valid (registered).
- `m0_rdata`, `m1_rdata` out 32: read data, equal to `mem_rdata` for both ports.
- `mem_valid`, `mem_write` out 1; `mem_wmask` out 4; `mem_wdata` out 32; `mem_addr` out ADDR_WIDTH: muxed request to memory.
- `mem_rdata` in 32: memory read data, valid the cycle after a read.

## Operation
- State: `last` (port granted in the most recent contested cycle), `wait0`, `wait1` (4-bit starvation counters), `rtag` (2-bit: rvalid for port 0/1).
- Grant, per cycle:
  - only one port valid → that port.
  - both valid, a wait counter ≥ MAX_WAIT → that port (port 0 if both).
  - both valid otherwise → arbitration policy (see Configuration).
  - none valid → no grant; `mem_valid`=0, mem buses carry port 0 values (don't care).
- `mX_ready` = grant to X. Granted port's fields drive `mem_*`; `mem_valid`=1.
- Counters: port valid and not granted → its counter increments (saturating at 15); granted or not valid → cleared.
- `last` updates only in contested cycles, to the granted port.
- `rtag[X]` ← grant to X and not write. `mX_rvalid` = `rtag[X]`.
- Writes produce no response; ready is their completion.
- A master must hold its request stable until ready; the arbiter does not buffer.

## Timing
- Request to memory: 0 cycles (combinational from `mX_valid` to `mem_valid`/`mX_ready`).
- Read data: accepted in cycle t → `mX_rvalid`=1 and data on `mX_rdata` in cycle t+1 only.
- Back-to-back: one transaction per cycle total; a port granted in t may be granted again in t+1.
- Reset values: `rtag`=0 (both rvalid 0), `last`=1 (port 0 wins first contest), `wait0`=`wait1`=0. `mX_ready` and `mem_valid` follow inputs combinationally, also during reset; masters must keep valid low while `rstn`=0.
- Reset asserted with a read outstanding: rvalid clears immediately; the response is dropped, not replayed.
- Simultaneous read on one port and write on the other: only the granted one proceeds; the other stalls with `ready`=0.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: contested cycles grant the port not equal to `last` (strict alternation).
- Not defined: contested cycles grant port 0 (fixed priority); port 1 progresses only via the MAX_WAIT starvation rule. `last` still maintained but unused.

## Test plan
- Single read port 0, addr 0x100 holding 0xDEADBEEF → `m0_ready`=1 same cycle, `m0_rvalid`=1 with 0xDEADBEEF next cycle, `m1_rvalid` stays 0.
- Port 1 write 0x12345678 mask 0b0011 to 0x200, then port 1 read 0x200 (prior 0xAAAAAAAA) → read returns 0xAAAA5678, one cycle latency.
- Both ports reading continuously, round-robin build → grants alternate 0,1,0,1 from reset; each rvalid pulses every other cycle with the correct data.
- Same stimulus, fixed priority, MAX_WAIT=4 → port 0 granted 4 cycles, port 1 on the 5th, pattern repeats; counter never exceeds 4.
- Port 0 read accepted, `rstn` pulled low mid-cycle before next edge → `m0_rvalid` 0 immediately and after reset release, no stray pulse.
- Port 0 write and port 1 read contested, `last`=0 in round-robin → port 1 read granted, port 0 ready=0 and write completes next cycle; memory contents checked afterwards.
